// File: rtl/booth_seq_64.sv
// Sequencer and working register for a 32x32 signed radix-2 Booth multiplier.
// Drives an external combinational partial-product adder and shifts its result back into P.
module booth_seq_64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [64:0] add_a,
    output logic [31:0] add_b,
    input  logic [64:0] add_r,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic        ovf
);

    // LOAD is the single settle cycle between operand capture and the first iteration,
    // which places done 33 clocks after the accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [64:0] p;
    logic [31:0] m;
    logic [5:0]  cnt;
    logic        ovf_pend;
    logic [64:0] p_shifted;
    logic        last_iter;

    assign p_shifted = {add_r[64], add_r[64:1]};
    assign last_iter = (cnt == 6'd31);
    assign add_a     = p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        add_b     = 32'd0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                case (p[1:0])
                    2'b01:   add_b = m;
                    2'b10:   add_b = ~m + 32'd1;
                    default: add_b = 32'd0;
                endcase
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p        <= 65'd0;
            m        <= 32'd0;
            cnt      <= 6'd0;
            ovf_pend <= 1'b0;
            product  <= 64'd0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        p        <= {32'd0, multiplier, 1'b0};
                        m        <= multiplicand;
                        cnt      <= 6'd0;
                        ovf_pend <= (multiplicand == 32'h8000_0000) && (multiplier != 32'd0);
                    end
                end
                RUN: begin
                    p   <= p_shifted;
                    cnt <= cnt + 6'd1;
                    // -M of the most negative multiplicand wraps, so that case is flagged.
                    if (last_iter) begin
                        product <= p_shifted[64:1];
                        ovf     <= ovf_pend;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_64.sv
// Testbench for booth_seq_64: models the external adder and checks results against
// the exact signed product plus the handshake timing.
module tb_booth_seq_64;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [64:0] add_a;
    logic [31:0] add_b;
    logic [64:0] add_r;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    booth_seq_64 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_r        (add_r),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .ovf          (ovf)
    );

    // Partial-product adder: operand B added into the A field, low bits passed through.
    assign add_r = {add_a[64:33] + add_b, add_a[32:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs one multiply; disturb re-pulses start with other operands in RUN and in DONE.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input bit disturb);
        int     lat;
        int     doneCount;
        int     sa;
        int     sb;
        longint expP;
        bit     expOvf;
        sa     = a;
        sb     = b;
        expP   = longint'(sa) * longint'(sb);
        expOvf = (a == 32'h8000_0000) && (b != 32'd0);
        applyStimulus(a, b);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        lat       = 0;
        doneCount = 0;
        for (int i = 1; i <= 40; i++) begin
            if (disturb && i == 5) begin
                multiplicand = ~a;
                multiplier   = b + 32'd1;
                start        = 1'b1;
            end
            if (disturb && i == 6) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                doneCount++;
                if (lat == 0) lat = i;
            end
            if (disturb && i == 33) begin
                multiplicand = 32'd9;
                multiplier   = 32'd9;
                start        = 1'b1;
            end
            if (disturb && i == 34) start = 1'b0;
            if (lat != 0 && i >= lat + 3) break;
        end
        checkOutput("latency", 64'(lat), 64'd33);
        checkOutput("done_pulses", 64'(doneCount), 64'd1);
        if (!expOvf) checkOutput("product", product, expP);
        checkOutput("ovf", 64'(ovf), 64'(expOvf));
        checkOutput("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_product", product, 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);
        checkOutput("rst_add_a", add_a[63:0], 64'd0);
        checkOutput("rst_add_b", 64'(add_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp(32'd3, 32'd5, 1'b0);
        checkOutput("prod_3x5", product, 64'h0000_0000_0000_000F);
        runOp(32'hFFFF_FFF9, 32'd6, 1'b0);
        checkOutput("prod_m7x6", product, 64'hFFFF_FFFF_FFFF_FFD6);
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        checkOutput("prod_maxpos", product, 64'h3FFF_FFFF_0000_0001);
        runOp(32'h1234_5678, 32'd0, 1'b0);
        runOp(32'h8000_0000, 32'd1, 1'b0);
        runOp(32'h8000_0000, 32'd0, 1'b0);
        runOp(32'h8000_0000, 32'h8000_0000, 1'b0);
        runOp(32'h0000_0007, 32'h8000_0000, 1'b0);
        runOp(32'd11, 32'hFFFF_FFFD, 1'b1);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 6 == 1) ra = 32'h8000_0000;
            if (n % 6 == 3) rb = 32'h8000_0000;
            if (n % 8 == 5) rb = 32'd0;
            runOp(ra, rb, (n % 5 == 2));
        end

        // Reset in the middle of an operation abandons it without a done pulse.
        applyStimulus(32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_product", product, 64'd0);
        checkOutput("midrst_add_a", add_a[63:0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp(32'd2, 32'd2, 1'b0);
        checkOutput("prod_2x2", product, 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
